seq_divider_4bit: RTL and testbench

Sequential 4-bit unsigned restoring divider: accepts a dividend/divisor pair on a start pulse and produces quotient and remainder after four iterations, one quotient bit per clock. It sits downstream of the operand registers and consumes the 4-bit adder/subtractor as its trial-subtract datapath. It completes the arithmetic set alongside the existing combinational adder/subtractor.

---
 rtl/seq_divider_4bit_pkg.sv | 18 +
 rtl/seq_divider_4bit_addsub.sv | 27 ++
 rtl/seq_divider_4bit.sv | 136 +++++++++++++
 tb/tb_seq_divider_4bit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_4bit_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_4bit_pkg
// Shared definitions for the 4-bit sequential restoring divider:
//   - state_e   : FSM state encodings (IDLE=0, RUN=1, DONE=2)
//   - DIV0_QUOT : quotient reported when the divisor is zero
// No ports (package).
// -----------------------------------------------------------------------------
package seq_divider_4bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] DIV0_QUOT = 4'hF;

endpackage : seq_divider_4bit_pkg

// File: rtl/seq_divider_4bit_addsub.sv
// -----------------------------------------------------------------------------
// adder_cum_sub_4bit
// Combinational 4-bit adder/subtractor. cin_i selects the operation:
//   cin_i=0 : sum_o = a_i + b_i,       cout_o = carry out
//   cin_i=1 : sum_o = a_i - b_i (mod 16), cout_o = 1 when no borrow (a_i >= b_i)
// Ports:
//   a_i    in  4  first operand
//   b_i    in  4  second operand
//   cin_i  in  1  carry in / subtract select
//   sum_o  out 4  sum or difference
//   cout_o out 1  carry out (no-borrow indication when subtracting)
// -----------------------------------------------------------------------------
module adder_cum_sub_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] b_eff;

  // Two's-complement subtract: invert b and inject the +1 through cin.
  assign b_eff           = b_i ^ {4{cin_i}};
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {4'b0000, cin_i};

endmodule : adder_cum_sub_4bit

// File: rtl/seq_divider_4bit.sv
// -----------------------------------------------------------------------------
// seq_divider_4bit
// Sequential 4-bit unsigned restoring divider, one quotient bit per clock.
// Nonzero divisor: start in cycle 0, busy in cycles 1-4, done in cycle 5.
// Zero divisor: done in cycle 1 with quotient=4'hF, remainder=dividend,
// div_by_zero=1, and no iterations.
// Ports:
//   clk         in  1  system clock, rising edge
//   rst         in  1  asynchronous active-high reset
//   start       in  1  request, accepted when busy=0
//   dividend    in  4  unsigned dividend, sampled with start
//   divisor     in  4  unsigned divisor, sampled with start
//   quotient    out 4  result quotient, updated on entry to DONE
//   remainder   out 4  result remainder, updated on entry to DONE
//   busy        out 1  high while iterating
//   done        out 1  one-cycle completion pulse
//   div_by_zero out 1  last accepted operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_divider_4bit
  import seq_divider_4bit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  // Working registers: Q shifts dividend out / quotient in, R is the partial
  // remainder, D holds the latched divisor.
  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic [3:0] d_q, d_d;

  logic [4:0] shift;
  logic [3:0] diff;
  logic       no_borrow;
  logic       take;

  assign shift = {r_q, q_q[3]};

  adder_cum_sub_4bit u_addsub (
    .a_i    (shift[3:0]),
    .b_i    (d_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (no_borrow)
  );

  // shift[4] set means S >= 16 > D, so the subtraction always succeeds and the
  // 4-bit difference is exact modulo 16 (S <= 29, result < D).
  assign take = shift[4] | no_borrow;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    case (state_q)
      ST_RUN: begin
        r_d   = take ? diff : shift[3:0];
        q_d   = {q_q[2:0], take};
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          quot_d  = {q_q[2:0], take};
          rem_d   = take ? diff : shift[3:0];
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; unused encoding acts as IDLE.
        state_d = ST_IDLE;
        if (start) begin
          if (divisor != 4'd0) begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = 4'd0;
            cnt_d   = 2'd3;
            dbz_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            quot_d  = DIV0_QUOT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    q_q <= q_d;
    r_q <= r_d;
    d_q <= d_d;
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule : seq_divider_4bit

// File: tb/tb_seq_divider_4bit.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_4bit
// Self-checking bench for seq_divider_4bit: directed vector table, hand-built
// multi-cycle sequences (ignored start, asynchronous reset abort) and a
// back-to-back sweep of all 256 operand pairs.
// -----------------------------------------------------------------------------
module tb_seq_divider_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         nbusy;
  } vec_t;

  vec_t vecs[6];

  seq_divider_4bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start in the current cycle (cycle 0) and wait for done.
  task automatic do_op(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                       input int elat, input int ebusy);
    int cycles;
    int nbusy;
    int overlap;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start  = 1'b0;
    cycles = 1;
    nbusy  = 0;
    overlap = 0;
    while (!done && cycles < 20) begin
      if (busy) nbusy++;
      tick();
      cycles++;
    end
    if (done && busy) overlap = 1;
    check({name, " latency"}, 8'(cycles), 8'(elat));
    check({name, " busy cycles"}, 8'(nbusy), 8'(ebusy));
    check({name, " done&busy"}, 8'(overlap), 8'd0);
    check({name, " quotient"}, {4'd0, quotient}, {4'd0, eq});
    check({name, " remainder"}, {4'd0, remainder}, {4'd0, er});
    check({name, " div_by_zero"}, {7'd0, div_by_zero}, {7'd0, edbz});
  endtask

  initial begin
    int ndone;
    int lat;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eq;
    logic [3:0] er;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1,  dbz: 1'b0, lat: 5, nbusy: 4};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  dbz: 1'b0, lat: 5, nbusy: 4};
    vecs[2] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7,  dbz: 1'b0, lat: 5, nbusy: 4};
    vecs[3] = '{a: 4'd14, b: 4'd15, q: 4'd0,  r: 4'd14, dbz: 1'b0, lat: 5, nbusy: 4};
    vecs[4] = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9,  dbz: 1'b1, lat: 1, nbusy: 0};
    vecs[5] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0,  dbz: 1'b0, lat: 5, nbusy: 4};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    #2;
    check("reset quotient", {4'd0, quotient}, 8'd0);
    check("reset remainder", {4'd0, remainder}, 8'd0);
    check("reset busy", {7'd0, busy}, 8'd0);
    check("reset done", {7'd0, done}, 8'd0);
    check("reset div_by_zero", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
            vecs[i].dbz, vecs[i].lat, vecs[i].nbusy);
    end
    tick();

    // 12/5 with a second start (15/1) in cycle 2 that must be ignored.
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    tick();
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    tick();
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    tick();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("ignored start latency", 8'(lat), 8'd5);
    check("ignored start quotient", {4'd0, quotient}, 8'd2);
    check("ignored start remainder", {4'd0, remainder}, 8'd2);
    tick();
    tick();

    // 11/2 aborted by asynchronous reset in cycle 3.
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort quotient", {4'd0, quotient}, 8'd0);
    check("abort remainder", {4'd0, remainder}, 8'd0);
    check("abort busy", {7'd0, busy}, 8'd0);
    check("abort done", {7'd0, done}, 8'd0);
    check("abort div_by_zero", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort no done pulse", 8'(ndone), 8'd0);
    do_op("after abort 11/2", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5, 4);
    tick();

    // Back-to-back sweep: start held high, new operands presented in each DONE cycle.
    start    = 1'b1;
    dividend = 4'd0;
    divisor  = 4'd0;
    for (int k = 0; k < 256; k++) begin
      a = 4'(k >> 4);
      b = 4'(k & 15);
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!done && lat < 20);
      if (b == 4'd0) begin
        eq = 4'hF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      check($sformatf("sweep %0d/%0d latency", a, b), 8'(lat), (b == 4'd0) ? 8'd1 : 8'd5);
      check($sformatf("sweep %0d/%0d quotient", a, b), {4'd0, quotient}, {4'd0, eq});
      check($sformatf("sweep %0d/%0d remainder", a, b), {4'd0, remainder}, {4'd0, er});
      check($sformatf("sweep %0d/%0d div_by_zero", a, b), {7'd0, div_by_zero},
            {7'd0, (b == 4'd0)});
      if (k < 255) begin
        dividend = 4'((k + 1) >> 4);
        divisor  = 4'((k + 1) & 15);
      end
    end
    start = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule : tb_seq_divider_4bit
